// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and defaults for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int REG_ZERO      = 0;
    localparam int DEF_NUM_REGS  = 32;
    localparam int DEF_REG_AW    = 5;
    localparam int DEF_LAT_W     = 3;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/hazard_scoreboard_reg_busy_slot.sv
// rtl/hazard_scoreboard_reg_busy_slot.sv - one register's latency countdown and variable-latency busy bit
module reg_busy_slot #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_issue_fix,
    input  logic             i_issue_var,
    input  logic [LAT_W-1:0] i_lat,
    input  logic             i_wb_clr,
    output logic             o_ready,
    output logic             o_vbusy
);

    logic [LAT_W-1:0] r_cnt;
    logic             r_vbusy;

    // A fresh issue overrides the countdown; a var issue freezes the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_issue_fix) begin
            r_cnt <= i_lat;
        end else if (!i_issue_var && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Set beats a same-cycle writeback clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vbusy <= 1'b0;
        end else if (i_issue_var) begin
            r_vbusy <= 1'b1;
        end else if (i_wb_clr) begin
            r_vbusy <= 1'b0;
        end
    end

    assign o_ready = (r_cnt == '0) && !r_vbusy;
    assign o_vbusy = r_vbusy;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage per-register scoreboard producing stall/bubble controls
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int REG_AW    = DEF_REG_AW,
    parameter int LAT_W     = DEF_LAT_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WAW_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_Valid,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic              ID_UseRs,
    input  logic              ID_UseRt,
    input  logic              ID_RegWrite,
    input  logic [REG_AW-1:0] ID_WriteReg,
    input  logic [LAT_W-1:0]  ID_Lat,
    input  logic              ID_VarLat,
    input  logic              Flush,
    input  logic              WB_Done,
    input  logic [REG_AW-1:0] WB_WriteReg,
    output logic              PCWr,
    output logic              IFIDWrite,
    output logic              IDEXClearCtrl,
    output logic              HazardRs,
    output logic              HazardRt,
    output logic [CNT_W-1:0]  StallCnt,
    output logic              ProtocolErr
);

    logic [NUM_REGS-1:0] w_ready;
    logic [NUM_REGS-1:0] w_vbusy;
    logic                w_rs_hz;
    logic                w_rt_hz;
    logic                w_wd_hz;
    logic                w_stall;
    logic                w_issue;
    logic                w_wb_bad;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                r_err;

    assign w_ready[REG_ZERO] = 1'b1;
    assign w_vbusy[REG_ZERO] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_slot
            logic w_hit;
            assign w_hit = w_issue && ID_RegWrite && (ID_WriteReg == REG_AW'(g));

            reg_busy_slot #(.LAT_W(LAT_W)) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_issue_fix (w_hit && !ID_VarLat),
                .i_issue_var (w_hit && ID_VarLat),
                .i_lat       (ID_Lat),
                .i_wb_clr    (WB_Done && (WB_WriteReg == REG_AW'(g))),
                .o_ready     (w_ready[g]),
                .o_vbusy     (w_vbusy[g])
            );
        end
    endgenerate

    assign w_rs_hz = ID_UseRs && !w_ready[ID_rs];
    assign w_rt_hz = ID_UseRt && !w_ready[ID_rt];
    assign w_wd_hz = (WAW_CHECK != 0) && ID_RegWrite && !w_ready[ID_WriteReg];
    assign w_stall = ID_Valid && !Flush && (w_rs_hz || w_rt_hz || w_wd_hz);
    assign w_issue = ID_Valid && !Flush && !w_stall;

    // Writeback to a register that was never marked variable-busy is a protocol violation.
    assign w_wb_bad = WB_Done && ((WB_WriteReg == REG_AW'(REG_ZERO)) || !w_vbusy[WB_WriteReg]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_wb_bad) begin
            r_err <= 1'b1;
        end
    end

    assign PCWr          = !w_stall;
    assign IFIDWrite     = !w_stall;
    assign IDEXClearCtrl = w_stall;
    assign HazardRs      = ID_Valid && w_rs_hz;
    assign HazardRt      = ID_Valid && w_rt_hz;
    assign StallCnt      = r_stall_cnt;
    assign ProtocolErr   = r_err;

endmodule
